// File: rtl/uart_tx_cfg.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_cfg
// Description : UART transmitter with per-frame configuration of data bits,
//               parity and stop bits. Words are taken over a valid/ready
//               handshake. One bit lasts bit_duration+1 clocks.
//
// Ports       : clk, rst        clock, synchronous active-high reset
//               s_valid/s_ready input handshake, s_data sent LSB first
//               bit_duration    clocks per bit minus 1 (latched on accept)
//               data_bits       data bits per frame, clamped to 5..DATA_W
//               parity          000 none, 001 even, 010 odd, 011 mark,
//                               100 space, others none
//               stopbits        00 one, 01 one-and-a-half, 1x two
//               break_req       hold the line low (UART_TX_BREAK_EN only)
//               tx              serial output, idle high
//               busy            high from accept until the frame ends
//               tx_done         pulse on the last cycle of the stop period
//
// Options     : define UART_TX_BREAK_EN to add break_req and the break state.
//
// Revision    : 1.0  initial release
// ============================================================================
module uart_tx_cfg #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic [CNT_W-1:0]  bit_duration,
    input  logic [3:0]        data_bits,
    input  logic [2:0]        parity,
    input  logic [1:0]        stopbits,
`ifdef UART_TX_BREAK_EN
    input  logic              break_req,
`endif
    output logic              tx,
    output logic              busy,
    output logic              tx_done
);

    localparam logic [2:0] c_IDLE     = 3'd0;
    localparam logic [2:0] c_START    = 3'd1;
    localparam logic [2:0] c_DATA     = 3'd2;
    localparam logic [2:0] c_PARITY   = 3'd3;
    localparam logic [2:0] c_STOP     = 3'd4;
    localparam logic [2:0] c_BREAK    = 3'd5;
    localparam logic [2:0] c_BRK_MARK = 3'd6;

    localparam logic [3:0]     c_MAX_BITS = 4'(DATA_W);
    localparam logic [3:0]     c_MIN_BITS = 4'd5;
    localparam logic [CNT_W:0] c_CNT_ONE  = (CNT_W+1)'(1);

    // The counter is one bit wider than bit_duration so that the longest
    // stop period (two bits) still fits as a single down-count.
    logic [2:0]        r_state;
    logic [CNT_W:0]    r_cnt;
    logic [CNT_W-1:0]  r_dur;
    logic [CNT_W:0]    r_stop_m1;
    logic [DATA_W-1:0] r_shift;
    logic [3:0]        r_idx;
    logic [3:0]        r_last_idx;
    logic              r_par_en;
    logic              r_par_val;
    logic              r_tx;
    logic              r_ready;
    logic              r_busy;
    logic              r_done;

    logic [3:0]        w_nbits;
    logic [DATA_W-1:0] w_mask;
    logic              w_xor;
    logic              w_par_en;
    logic              w_par_val;
    logic [CNT_W:0]    w_dur_ext;
    logic [CNT_W:0]    w_stop_m1;

    always_comb begin
        w_nbits = data_bits;
        if (data_bits < c_MIN_BITS)
            w_nbits = c_MIN_BITS;
        else if (data_bits > c_MAX_BITS)
            w_nbits = c_MAX_BITS;
    end

    // Parity only covers the bits actually sent after clamping.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < DATA_W; i++)
            w_mask[i] = (i < int'(w_nbits));
    end

    assign w_xor = ^(s_data & w_mask);

    always_comb begin
        w_par_en  = 1'b0;
        w_par_val = 1'b0;
        case (parity)
            3'b001:  begin w_par_en = 1'b1; w_par_val = w_xor;  end
            3'b010:  begin w_par_en = 1'b1; w_par_val = ~w_xor; end
            3'b011:  begin w_par_en = 1'b1; w_par_val = 1'b1;   end
            3'b100:  begin w_par_en = 1'b1; w_par_val = 1'b0;   end
            default: begin w_par_en = 1'b0; w_par_val = 1'b0;   end
        endcase
    end

    // Stop period length minus one, in clocks.
    assign w_dur_ext = {1'b0, bit_duration};
    always_comb begin
        case (stopbits)
            2'b00:   w_stop_m1 = w_dur_ext;
            2'b01:   w_stop_m1 = w_dur_ext + (w_dur_ext >> 1) + c_CNT_ONE;
            default: w_stop_m1 = (w_dur_ext << 1) + c_CNT_ONE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_cnt      <= '0;
            r_dur      <= '0;
            r_stop_m1  <= '0;
            r_shift    <= '0;
            r_idx      <= '0;
            r_last_idx <= '0;
            r_par_en   <= 1'b0;
            r_par_val  <= 1'b0;
            r_tx       <= 1'b1;
            r_ready    <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
`ifdef UART_TX_BREAK_EN
                    if (break_req) begin
                        r_state <= c_BREAK;
                        r_dur   <= bit_duration;
                        r_tx    <= 1'b0;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                    end else
`endif
                    if (s_valid && r_ready) begin
                        r_state    <= c_START;
                        r_dur      <= bit_duration;
                        r_cnt      <= w_dur_ext;
                        r_stop_m1  <= w_stop_m1;
                        r_shift    <= s_data;
                        r_idx      <= '0;
                        r_last_idx <= w_nbits - 4'd1;
                        r_par_en   <= w_par_en;
                        r_par_val  <= w_par_val;
                        r_tx       <= 1'b0;
                        r_ready    <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                c_START: begin
                    if (r_cnt == '0) begin
                        r_state <= c_DATA;
                        r_cnt   <= {1'b0, r_dur};
                        r_tx    <= r_shift[0];
                    end else begin
                        r_cnt <= r_cnt - c_CNT_ONE;
                    end
                end
                c_DATA: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - c_CNT_ONE;
                    end else if (r_idx != r_last_idx) begin
                        r_idx   <= r_idx + 4'd1;
                        r_shift <= r_shift >> 1;
                        r_tx    <= r_shift[1];
                        r_cnt   <= {1'b0, r_dur};
                    end else if (r_par_en) begin
                        r_state <= c_PARITY;
                        r_tx    <= r_par_val;
                        r_cnt   <= {1'b0, r_dur};
                    end else begin
                        r_state <= c_STOP;
                        r_tx    <= 1'b1;
                        r_cnt   <= r_stop_m1;
                        r_done  <= (r_stop_m1 == '0);
                    end
                end
                c_PARITY: begin
                    if (r_cnt == '0) begin
                        r_state <= c_STOP;
                        r_tx    <= 1'b1;
                        r_cnt   <= r_stop_m1;
                        r_done  <= (r_stop_m1 == '0);
                    end else begin
                        r_cnt <= r_cnt - c_CNT_ONE;
                    end
                end
                c_STOP: begin
                    // tx_done is raised one edge early so it coincides with
                    // the final stop cycle.
                    if (r_cnt == '0) begin
                        r_state <= c_IDLE;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt  <= r_cnt - c_CNT_ONE;
                        r_done <= (r_cnt == c_CNT_ONE);
                    end
                end
`ifdef UART_TX_BREAK_EN
                c_BREAK: begin
                    if (!break_req) begin
                        r_state <= c_BRK_MARK;
                        r_tx    <= 1'b1;
                        r_cnt   <= {1'b0, r_dur};
                    end
                end
                c_BRK_MARK: begin
                    if (r_cnt == '0) begin
                        r_state <= c_IDLE;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - c_CNT_ONE;
                    end
                end
`endif
                default: begin
                    r_state <= c_IDLE;
                    r_tx    <= 1'b1;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Gating with rst keeps s_ready low during reset while letting it be
    // high on the very first cycle after reset is released.
    assign s_ready = r_ready & ~rst;
    assign busy    = r_busy & ~rst;
    assign tx      = r_tx;
    assign tx_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_cfg.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_cfg
// Description : Self-checking bench for uart_tx_cfg. Frame configurations are
//               held in a vector table; the expected per-clock tx waveform of
//               each frame is queued when the word is handed over and popped
//               cycle by cycle as the transmitter produces it.
// Revision    : 1.0  initial release
// ============================================================================
module tb_uart_tx_cfg;

    typedef struct {
        logic [7:0] data;
        int         dur;
        int         dbits;
        int         par;
        int         stop;
        int         exp_len;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [7:0]  s_data = 8'h00;
    logic [15:0] bit_duration = 16'd0;
    logic [3:0]  data_bits = 4'd8;
    logic [2:0]  parity = 3'd0;
    logic [1:0]  stopbits = 2'd0;
`ifdef UART_TX_BREAK_EN
    logic        break_req = 1'b0;
`endif
    logic        tx;
    logic        busy;
    logic        tx_done;

    int n_total = 0;
    int n_bad   = 0;
    logic q_tx[$];
    vec_t vecs[9];

    uart_tx_cfg #(.DATA_W(8), .CNT_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .bit_duration (bit_duration),
        .data_bits    (data_bits),
        .parity       (parity),
        .stopbits     (stopbits),
`ifdef UART_TX_BREAK_EN
        .break_req    (break_req),
`endif
        .tx           (tx),
        .busy         (busy),
        .tx_done      (tx_done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input logic act, input logic exp, input string nm);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b want %b", nm, act, exp);
        end
    endtask

    task automatic check_int(input int act, input int exp, input string nm);
        n_total++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    // Reference model: per-clock tx level of a whole frame.
    task automatic build_expected(input vec_t v);
        int   nb;
        int   stop_len;
        logic x;
        nb = (v.dbits < 5) ? 5 : ((v.dbits > 8) ? 8 : v.dbits);
        for (int k = 0; k <= v.dur; k++) q_tx.push_back(1'b0);
        x = 1'b0;
        for (int i = 0; i < nb; i++) begin
            x = x ^ v.data[i];
            for (int k = 0; k <= v.dur; k++) q_tx.push_back(v.data[i]);
        end
        if (v.par >= 1 && v.par <= 4) begin
            logic pb;
            case (v.par)
                1:       pb = x;
                2:       pb = ~x;
                3:       pb = 1'b1;
                default: pb = 1'b0;
            endcase
            for (int k = 0; k <= v.dur; k++) q_tx.push_back(pb);
        end
        case (v.stop)
            0:       stop_len = v.dur + 1;
            1:       stop_len = (v.dur + 1) + (v.dur / 2 + 1);
            default: stop_len = 2 * (v.dur + 1);
        endcase
        for (int k = 0; k < stop_len; k++) q_tx.push_back(1'b1);
    endtask

    task automatic wait_ready(input string nm);
        int n;
        n = 0;
        @(negedge clk);
        while (s_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check(s_ready, 1'b1, {nm, " ready timeout"});
    endtask

    task automatic drive_cfg(input vec_t v);
        s_data       = v.data;
        bit_duration = 16'(v.dur);
        data_bits    = 4'(v.dbits);
        parity       = 3'(v.par);
        stopbits     = 2'(v.stop);
    endtask

    // Pops the queued waveform one clock at a time after the accept edge.
    task automatic run_frame(input int exp_len, input string nm, input bit keep_valid);
        int   cyc;
        int   done_at;
        logic e;
        cyc     = 0;
        done_at = -1;
        while (q_tx.size() > 0) begin
            @(negedge clk);
            if (cyc == 0 && !keep_valid) begin
                s_valid      = 1'b0;
                s_data       = 8'($urandom);
                bit_duration = 16'($urandom_range(0, 7));
                data_bits    = 4'($urandom);
                parity       = 3'($urandom);
                stopbits     = 2'($urandom);
            end
            cyc++;
            e = q_tx.pop_front();
            check(tx, e, $sformatf("%s tx@%0d", nm, cyc));
            check(tx_done, (q_tx.size() == 0), $sformatf("%s done@%0d", nm, cyc));
            check(s_ready, 1'b0, $sformatf("%s ready@%0d", nm, cyc));
            check(busy, 1'b1, $sformatf("%s busy@%0d", nm, cyc));
            if (tx_done === 1'b1 && done_at < 0) done_at = cyc;
        end
        check_int(done_at, exp_len, {nm, " done latency"});
    endtask

    task automatic send(input vec_t v, input string nm);
        wait_ready(nm);
        drive_cfg(v);
        s_valid = 1'b1;
        @(posedge clk);
        build_expected(v);
        run_frame(v.exp_len, nm, 1'b0);
        @(negedge clk);
        check(s_ready, 1'b1, {nm, " ready after"});
        check(busy, 1'b0, {nm, " busy after"});
        check(tx, 1'b1, {nm, " idle tx"});
        check(tx_done, 1'b0, {nm, " done after"});
    endtask

    initial begin
        vec_t v1, v2;
        //          data   D  bits par stop len
        vecs[0] = '{8'hA5, 3, 8,   0,  0,   40};
        vecs[1] = '{8'h03, 1, 7,   1,  2,   22};
        vecs[2] = '{8'h03, 1, 7,   2,  2,   22};
        vecs[3] = '{8'hA5, 4, 8,   0,  1,   53};
        vecs[4] = '{8'hF3, 0, 3,   3,  0,   8};
        vecs[5] = '{8'h96, 0, 15,  4,  1,   12};
        vecs[6] = '{8'h3C, 2, 8,   7,  3,   33};
        vecs[7] = '{8'h00, 0, 8,   0,  0,   10};
        vecs[8] = '{8'h55, 1, 8,   0,  0,   20};

        // Reset state
        repeat (3) @(negedge clk);
        check(tx, 1'b1, "rst tx");
        check(s_ready, 1'b0, "rst ready");
        check(busy, 1'b0, "rst busy");
        check(tx_done, 1'b0, "rst done");
        rst = 1'b0;
        @(negedge clk);
        check(s_ready, 1'b1, "post-rst ready");
        check(busy, 1'b0, "post-rst busy");

        for (int i = 0; i < 8; i++) send(vecs[i], $sformatf("vec%0d", i));

        // Back-to-back words with s_valid held high
        v1 = '{8'h5A, 0, 8, 0, 0, 10};
        v2 = '{8'hC3, 0, 8, 0, 0, 10};
        wait_ready("b2b");
        drive_cfg(v1);
        s_valid = 1'b1;
        @(posedge clk);
        build_expected(v1);
        @(negedge clk);
        s_data = v2.data;
        q_tx.push_front(1'b0);
        // first cycle already reached; compare it here then continue
        begin
            logic e;
            e = q_tx.pop_front();
            e = q_tx.pop_front();
            check(tx, e, "b2b first tx@1");
            check(s_ready, 1'b0, "b2b first ready@1");
        end
        run_frame(9, "b2b first", 1'b1);
        @(negedge clk);
        check(s_ready, 1'b1, "b2b idle ready");
        check(tx, 1'b1, "b2b idle tx");
        @(posedge clk);
        build_expected(v2);
        run_frame(10, "b2b second", 1'b0);

        // Reset in the middle of the data bits
        wait_ready("mid-rst");
        drive_cfg('{8'h00, 3, 8, 0, 0, 40});
        s_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s_valid = 1'b0;
        repeat (7) @(negedge clk);
        check(tx, 1'b0, "mid-rst data low");
        rst = 1'b1;
        @(negedge clk);
        check(tx, 1'b1, "mid-rst tx");
        check(busy, 1'b0, "mid-rst busy");
        check(s_ready, 1'b0, "mid-rst ready");
        check(tx_done, 1'b0, "mid-rst done");
        @(negedge clk);
        check(tx_done, 1'b0, "mid-rst done2");
        rst = 1'b0;
        @(negedge clk);
        check(s_ready, 1'b1, "mid-rst ready after");
        check(tx_done, 1'b0, "mid-rst done3");
        send(vecs[8], "after-rst 55");

`ifdef UART_TX_BREAK_EN
        // Break: 20 clocks low, then one 3-clock mark bit; s_valid ignored
        wait_ready("brk");
        bit_duration = 16'd2;
        s_data       = 8'h00;
        break_req    = 1'b1;
        s_valid      = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            bit_duration = 16'd9;
            check(tx, 1'b0, $sformatf("brk low@%0d", k));
            check(s_ready, 1'b0, $sformatf("brk ready@%0d", k));
            check(busy, 1'b1, $sformatf("brk busy@%0d", k));
            check(tx_done, 1'b0, $sformatf("brk done@%0d", k));
            if (k == 20) begin
                break_req = 1'b0;
                s_valid   = 1'b0;
            end
        end
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check(tx, 1'b1, $sformatf("brk mark@%0d", k));
            check(s_ready, 1'b0, $sformatf("brk mark ready@%0d", k));
            check(tx_done, 1'b0, $sformatf("brk mark done@%0d", k));
        end
        @(negedge clk);
        check(s_ready, 1'b1, "brk ready after");
        check(tx, 1'b1, "brk tx after");
        @(negedge clk);
        check(tx, 1'b1, "brk no accept");
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
